// File: rtl/spi_gatherer_pkg.sv
// Shared receive/transmit attribute indices and the bytes-per-word helpers.
package spi_gatherer_pkg;

    localparam int unsigned INVALID    = 0;
    localparam int unsigned VALID      = 1;
    localparam int unsigned SPI_FINISH = 2;
    localparam int unsigned FULL       = 3;

    function automatic int unsigned calc_bpw(input int unsigned dw, input int unsigned sdw);
        return dw / sdw;
    endfunction

    function automatic int unsigned calc_cnt_width(input int unsigned bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/spi_gatherer_if.sv
// Byte-in / word-out bus between the SPI deserializer, the gatherer and the processing unit.
interface spi_gatherer_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SPI_DATA_WIDTH = 8,
    parameter int unsigned ATTR_WIDTH     = 4
) ();

    logic                      byte_ready;
    logic [SPI_DATA_WIDTH-1:0] data_in_byte;
    logic                      flag_start;
    logic                      flag_stop;
    logic                      oe;
    logic [DATA_WIDTH-1:0]     data_out;
    logic [ATTR_WIDTH-1:0]     attr_gatherer;

    modport master (
        output byte_ready, data_in_byte, flag_start, flag_stop, oe,
        input  data_out, attr_gatherer
    );

    modport slave (
        input  byte_ready, data_in_byte, flag_start, flag_stop, oe,
        output data_out, attr_gatherer
    );

endinterface

// File: rtl/spi_gatherer_buffer.sv
// Two-entry ping-pong word store: commit/pop arbitration, occupancy flags, overflow pulse.
module spi_gatherer_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  overflow_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  wptr_q, rptr_q;
    logic [1:0]            count_q, count_d;
    logic                  valid_q, full_q;
    logic                  do_pop, do_push;

    // A pop in the same cycle frees a slot, so a commit into a full buffer is still accepted.
    always_comb begin
        do_pop     = rd_i && (count_q != 2'd0);
        do_push    = wr_i && ((count_q != 2'd2) || do_pop);
        overflow_o = wr_i && !do_push;
        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rdata_q  <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (do_pop) begin
                rdata_q <= mem_q[rptr_q];
                rptr_q  <= ~rptr_q;
            end
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
            full_q  <= (count_d == 2'd2);
        end
    end

    assign rdata_o = rdata_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;

endmodule

// File: rtl/spi_gatherer.sv
// Packs deserializer bytes MSB-first into words and exports receive status on the attribute bus.
// Optional GATHER_PARTIAL_FLUSH_EN: flag_stop commits a zero-padded partial word a cycle later.
module spi_gatherer
    import spi_gatherer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SPI_DATA_WIDTH = 8,
    parameter int unsigned ATTR_WIDTH     = 4,
    parameter int unsigned INVALID_IDX    = INVALID,
    parameter int unsigned VALID_IDX      = VALID,
    parameter int unsigned FINISH_IDX     = SPI_FINISH,
    parameter int unsigned FULL_IDX       = FULL
) (
    input logic          clk,
    input logic          rst,
    spi_gatherer_if.slave bus_io
);

    localparam int unsigned BPW  = calc_bpw(DATA_WIDTH, SPI_DATA_WIDTH);
    localparam int unsigned CntW = calc_cnt_width(BPW);

    logic                  ready_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  invalid_q, finish_q;
    logic                  byte_edge, byte_commit;
    logic                  commit;
    logic [DATA_WIDTH-1:0] commit_word;
    logic                  valid, full, overflow;
    logic [ATTR_WIDTH-1:0] attr;
`ifdef GATHER_PARTIAL_FLUSH_EN
    logic                  flush_q, flush_d;
    logic [DATA_WIDTH-1:0] flush_word_q, flush_word_d;
    logic [31:0]           pad_bits;
`endif

    assign byte_edge = bus_io.byte_ready && !ready_q;

    // flag_start clears assembly first so a coincident byte lands as byte 0 of the new word.
    always_comb begin
        shift_d     = bus_io.flag_start ? '0 : shift_q;
        cnt_d       = bus_io.flag_start ? '0 : cnt_q;
        byte_commit = 1'b0;
        if (byte_edge) begin
            shift_d = (shift_d << SPI_DATA_WIDTH) | DATA_WIDTH'(bus_io.data_in_byte);
            if (cnt_d == CntW'(BPW - 1)) begin
                byte_commit = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_d + 1'b1;
            end
        end
`ifdef GATHER_PARTIAL_FLUSH_EN
        flush_d      = 1'b0;
        flush_word_d = flush_word_q;
        pad_bits     = SPI_DATA_WIDTH * (BPW - 32'(cnt_d));
        if (bus_io.flag_stop && (cnt_d != '0)) begin
            flush_d      = 1'b1;
            flush_word_d = shift_d << pad_bits;
        end
`endif
        if (bus_io.flag_stop) begin
            cnt_d = '0;
        end
    end

`ifdef GATHER_PARTIAL_FLUSH_EN
    assign commit      = flush_q || byte_commit;
    assign commit_word = flush_q ? flush_word_q : shift_d;
`else
    assign commit      = byte_commit;
    assign commit_word = shift_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q   <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
            finish_q  <= 1'b0;
`ifdef GATHER_PARTIAL_FLUSH_EN
            flush_q      <= 1'b0;
            flush_word_q <= '0;
`endif
        end else begin
            ready_q   <= bus_io.byte_ready;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            invalid_q <= (bus_io.flag_start ? 1'b0 : invalid_q) | overflow;
            finish_q  <= (bus_io.flag_start ? 1'b0 : finish_q) | bus_io.flag_stop;
`ifdef GATHER_PARTIAL_FLUSH_EN
            flush_q      <= flush_d;
            flush_word_q <= flush_word_d;
`endif
        end
    end

    spi_gatherer_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (commit),
        .wdata_i   (commit_word),
        .rd_i      (bus_io.oe),
        .rdata_o   (bus_io.data_out),
        .valid_o   (valid),
        .full_o    (full),
        .overflow_o(overflow)
    );

    always_comb begin
        attr              = '0;
        attr[INVALID_IDX] = invalid_q;
        attr[VALID_IDX]   = valid;
        attr[FINISH_IDX]  = finish_q;
        attr[FULL_IDX]    = full;
    end

    assign bus_io.attr_gatherer = attr;

endmodule

// File: tb/tb_spi_gatherer.sv
// Self-checking bench for spi_gatherer: directed vector table, corner sequences, random vs model.
module tb_spi_gatherer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_gatherer_if #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .ATTR_WIDTH(4)) bus ();

    spi_gatherer dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bytes accumulate arithmetically, stored words sit in a bounded queue.
    logic        m_prev;
    logic [31:0] m_word;
    int          m_nb;
    logic [31:0] m_q[$];
    logic [31:0] m_dout;
    logic        m_inv, m_fin;
    logic        m_pend;
    logic [31:0] m_pend_word;

    typedef struct {
        logic        br;
        logic [7:0]  b;
        logic        fs;
        logic        fp;
        logic        oe;
        logic [31:0] exp_dout;
        logic [3:0]  exp_attr;
    } vec_t;

    function automatic logic [3:0] m_attr();
        logic [3:0] a;
        a[0] = m_inv;
        a[1] = (m_q.size() > 0);
        a[2] = m_fin;
        a[3] = (m_q.size() == 2);
        return a;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_prev = 1'b0; m_word = '0; m_nb = 0; m_q.delete(); m_dout = '0;
        m_inv = 1'b0; m_fin = 1'b0; m_pend = 1'b0; m_pend_word = '0;
    endtask

    task automatic model_update(input logic br, input logic [7:0] b, input logic fs,
                                input logic fp, input logic oe);
        int          nb;
        logic [31:0] w, cw;
        bit          commit, pop, had_pend;
        logic [31:0] pw;
        nb = fs ? 0 : m_nb;
        w  = fs ? 32'd0 : m_word;
        commit = 0; cw = '0;
        pop = oe && (m_q.size() > 0);
        had_pend = m_pend; pw = m_pend_word; m_pend = 1'b0;
        if (br && !m_prev) begin
            w = (w << 8) | {24'd0, b};
            nb++;
            if (nb == 4) begin commit = 1; cw = w; nb = 0; end
        end
        if (fp) begin
`ifdef GATHER_PARTIAL_FLUSH_EN
            if (nb != 0) begin m_pend = 1'b1; m_pend_word = w << (8 * (4 - nb)); end
`endif
            nb = 0;
        end
        if (had_pend) begin commit = 1; cw = pw; end
        if (fs) begin m_inv = 1'b0; m_fin = 1'b0; end
        if (fp) m_fin = 1'b1;
        if (pop) m_dout = m_q.pop_front();
        if (commit) begin
            if (m_q.size() < 2) m_q.push_back(cw);
            else m_inv = 1'b1;
        end
        m_nb = nb; m_word = w; m_prev = br;
    endtask

    task automatic step(input logic br, input logic [7:0] b, input logic fs, input logic fp,
                        input logic oe);
        bus.byte_ready = br; bus.data_in_byte = b;
        bus.flag_start = fs; bus.flag_stop = fp; bus.oe = oe;
        model_update(br, b, fs, fp, oe);
        @(posedge clk);
        #1;
        check32("model data_out", bus.data_out, m_dout);
        check32("model attr", {28'd0, bus.attr_gatherer}, {28'd0, m_attr()});
    endtask

    task automatic send_byte(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
        step(1'b0, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic pop_expect(input string name, input logic [31:0] exp);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check32(name, bus.data_out, exp);
    endtask

    task automatic do_reset();
        bus.byte_ready = 1'b0; bus.data_in_byte = '0; bus.flag_start = 1'b0;
        bus.flag_stop = 1'b0; bus.oe = 1'b0;
        rst = 1'b1;
        model_clear();
        #1;
        check32("reset data_out", bus.data_out, 32'd0);
        check32("reset attr", {28'd0, bus.attr_gatherer}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    vec_t vecs[9];
    logic [7:0] rb;
    logic       rbr;

    initial begin
        rst = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Basic word assembly and pop, one row per cycle.
        vecs[0] = '{1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000};
        vecs[1] = '{1'b0, 8'hDE, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000};
        vecs[2] = '{1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000};
        vecs[3] = '{1'b0, 8'hAD, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000};
        vecs[4] = '{1'b1, 8'hBE, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000};
        vecs[5] = '{1'b0, 8'hBE, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000};
        vecs[6] = '{1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0010};
        vecs[7] = '{1'b0, 8'hEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0000};
        vecs[8] = '{1'b0, 8'hEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].br, vecs[i].b, vecs[i].fs, vecs[i].fp, vecs[i].oe);
            check32($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].exp_dout);
            check32($sformatf("vec%0d attr", i), {28'd0, bus.attr_gatherer},
                    {28'd0, vecs[i].exp_attr});
        end

        // Overflow: third word dropped, INVALID sticky.
        send_word(32'h10111213);
        send_word(32'h20212223);
        send_word(32'h30313233);
        check32("overflow attr", {28'd0, bus.attr_gatherer}, 32'b1011);
        pop_expect("overflow pop1", 32'h10111213);
        pop_expect("overflow pop2", 32'h20212223);
        check32("overflow attr after pops", {28'd0, bus.attr_gatherer}, 32'b0001);

        // flag_start coinciding with a byte edge restarts the word.
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check32("start attr", {28'd0, bus.attr_gatherer}, 32'b0010);
        pop_expect("start pop", 32'hAABBCCDD);

        // Commit into full buffer with simultaneous pop.
        send_word(32'hA0A1A2A3);
        send_word(32'hB0B1B2B3);
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        check32("coincide pop", bus.data_out, 32'hA0A1A2A3);
        check32("coincide attr", {28'd0, bus.attr_gatherer}, 32'b1010);
        step(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
        pop_expect("coincide pop2", 32'hB0B1B2B3);
        pop_expect("coincide pop3", 32'hC0C1C2C3);

        // Partial word then flag_stop.
        send_byte(8'h11); send_byte(8'h22);
        step(1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
        check32("stop attr", {28'd0, bus.attr_gatherer}, 32'b0100);
        step(1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
`ifdef GATHER_PARTIAL_FLUSH_EN
        check32("flush attr", {28'd0, bus.attr_gatherer}, 32'b0110);
        pop_expect("flush pop", 32'h11220000);
`else
        check32("discard attr", {28'd0, bus.attr_gatherer}, 32'b0100);
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-word.
        send_byte(8'h12); send_byte(8'h34);
        do_reset();
        send_word(32'h01020304);
        pop_expect("post-reset pop", 32'h01020304);

        // byte_ready held high captures one byte.
        for (int i = 0; i < 10; i++) step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        pop_expect("held-high pop", 32'h5A010203);

        // Random traffic against the model.
        rb = 8'h00; rbr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rbr = 1'($urandom_range(0, 1));
            if (!rbr) rb = 8'($urandom);
            step(rbr, rb, ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
